// File: rtl/cotm32_pkg.sv
// Core-wide constants shared by the datapath blocks.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cotm32_pkg;
   parameter int XLEN       = 32;
   parameter int BYTE_WIDTH = 8;
endpackage

// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns one LSU load/store into one aligned bus word access.
// Latency: response 2 cycles after accept when the bus is ready at once; 1 cycle for misaligned requests.
// Backpressure: one request in flight; o_req_ready only in IDLE; the bus stalls via i_mem_ready and is aborted after TIMEOUT_CYCLES.
//
// Ports:
//   i_clk, i_rst_n                   clock, async active-low reset
//   i_req_* / o_req_ready            LSU request (lane-0 aligned data and size mask)
//   o_rsp_valid/o_rsp_rdata/o_rsp_err one-cycle response pulse, data shifted back to lane 0
//   o_mem_* / i_mem_*                word-aligned bus with byte strobes, ready and error
//   o_busy                           controller not idle
module dmem_ctrl
   import cotm32_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_req_valid,
   output logic            o_req_ready,
   input  logic            i_req_we,
   input  logic [XLEN-1:0] i_req_addr,
   input  logic [XLEN-1:0] i_req_wdata,
   input  logic [3:0]      i_req_be,
   output logic            o_rsp_valid,
   output logic [XLEN-1:0] o_rsp_rdata,
   output logic            o_rsp_err,
   output logic            o_mem_valid,
   input  logic            i_mem_ready,
   output logic [XLEN-1:0] o_mem_addr,
   output logic            o_mem_we,
   output logic [XLEN-1:0] o_mem_wdata,
   output logic [3:0]      o_mem_wstrb,
   input  logic [XLEN-1:0] i_mem_rdata,
   input  logic            i_mem_err,
   output logic            o_busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

   state_t          state, state_nxt;
   logic [XLEN-1:0] addr_q;
   logic [1:0]      off_q;
   logic            we_q;
   logic [XLEN-1:0] wdata_q;
   logic [3:0]      wstrb_q;
   logic [7:0]      cnt_q;
   logic [XLEN-1:0] rsp_rdata_q;
   logic            rsp_err_q;

   logic            accept;
   logic            misaligned;
   logic [7:0]      cnt_inc;
   logic            timeout;

   assign accept = i_req_valid && (state == IDLE);

   // Only byte, aligned half and aligned word masks are legal.
   always_comb begin
      misaligned = 1'b0;
      case (i_req_be)
         4'b0001: misaligned = 1'b0;
         4'b0011: misaligned = i_req_addr[0];
         4'b1111: misaligned = (i_req_addr[1:0] != 2'b00);
         default: misaligned = 1'b1;
      endcase
   end

   // cnt_q counts completed wait cycles; abort when this cycle would make it TMO.
   // A ready in the same cycle takes priority over the abort.
   assign cnt_inc = cnt_q + 8'd1;
   assign timeout = !i_mem_ready && (cnt_inc == TMO);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = misaligned ? RESP : BUS;
         BUS:     if (i_mem_ready || timeout) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         addr_q      <= '0;
         off_q       <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         cnt_q       <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (accept) begin
                  // Request is steered onto its byte lanes once, here, so the
                  // bus outputs stay stable for the whole BUS phase.
                  addr_q  <= {i_req_addr[XLEN-1:2], 2'b00};
                  off_q   <= i_req_addr[1:0];
                  we_q    <= i_req_we;
                  wdata_q <= i_req_wdata << (BYTE_WIDTH * i_req_addr[1:0]);
                  wstrb_q <= i_req_we ? (i_req_be << i_req_addr[1:0]) : 4'b0000;
                  cnt_q   <= '0;
                  if (misaligned) begin
                     rsp_rdata_q <= '0;
                     rsp_err_q   <= 1'b1;
                  end
               end
            end
            BUS: begin
               if (i_mem_ready) begin
                  rsp_rdata_q <= we_q ? '0 : (i_mem_rdata >> (BYTE_WIDTH * off_q));
                  rsp_err_q   <= i_mem_err;
               end else begin
                  cnt_q <= cnt_inc;
                  if (timeout) begin
                     rsp_rdata_q <= '0;
                     rsp_err_q   <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Bus valid is decoded from state so an async reset drops it immediately.
   assign o_req_ready = (state == IDLE);
   assign o_busy      = (state != IDLE);
   assign o_mem_valid = (state == BUS);
   assign o_mem_addr  = addr_q;
   assign o_mem_we    = we_q;
   assign o_mem_wdata = wdata_q;
   assign o_mem_wstrb = wstrb_q;
   assign o_rsp_valid = (state == RESP);
   assign o_rsp_rdata = rsp_rdata_q;
   assign o_rsp_err   = rsp_err_q;

endmodule
